multicycle_control: RTL and testbench
=====================================

# multicycle_control

Moore-style control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states, driving datapath enables and mux selects per cycle. Adds a memory-ready handshake with bounded wait, and a sticky trap for illegal opcodes or memory timeouts. Sits beside the register file, ALU control and memory interface.

## Interface
- MEM_TIMEOUT, 16: maximum cycles to wait for memReady in one memory state; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; MEM_TIMEOUT < 2^CNT_W.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- opCode  in  6  instruction bits [31:26], held stable by the IR after fetch.
- memReady  in  1  memory completes the current access this cycle.
- pcWrite, pcWriteCond, pcWriteCondNe  out  1  unconditional PC write, PC write on beq zero, PC write on bne not-zero.
- iorD, memRead, memWrite, irWrite  out  1  memory address select (1 = ALUOut), memory strobes, IR load.
- memReg, regDst, regWrite  out  1  write-back source (1 = MDR), destination select (1 = rd), register-file write.
- ALUSrcA  out  1  ALU A source (0 = PC, 1 = rs).
- ALUSrcB  out  2  ALU B source (00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate).
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct, 11 = and.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- trap  out  1  sticky error flag.
- state  out  4  current state code, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000, andi 001100.
- Opcode is latched into an internal register in DECODE. All later states decode the latched copy.
- States, with outputs asserted (all others 0):
  - START: no outputs. Next state FETCH.
  - FETCH: memRead, ALUSrcB=01. When memReady is high, also pcWrite and irWrite, and go to DECODE; otherwise hold.
  - DECODE: ALUSrcB=11. Next state by opcode:
    - lw/sw → MEM_ADDR
    - R-type → R_EXEC
    - beq/bne → BRANCH
    - j → JUMP
    - addi/andi → I_EXEC
    - any other opcode → TRAP
  - MEM_ADDR: ALUSrcA, ALUSrcB=10. Next MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ: memRead, iorD. Wait for memReady, then MEM_WB.
  - MEM_WB: memReg, regWrite. Next FETCH.
  - MEM_WRITE: memWrite, iorD. Wait for memReady, then FETCH.
  - R_EXEC: ALUSrcA, ALUOp=10. Next R_WB.
  - R_WB: regDst, regWrite. Next FETCH.
  - BRANCH: ALUSrcA, ALUOp=01, PCSource=01, plus pcWriteCond (beq) or pcWriteCondNe (bne). Next FETCH.
  - JUMP: pcWrite, PCSource=10. Next FETCH.
  - I_EXEC: ALUSrcA, ALUSrcB=10, ALUOp=00 (addi) or 11 (andi). Next I_WB.
  - I_WB: regWrite. Next FETCH.
  - TRAP: trap=1, all other outputs 0. Absorbing; left only by reset.
- Wait counter behaviour:
  - Clears on entry to any memory state (FETCH, MEM_READ, MEM_WRITE).
  - Increments on each cycle in a memory state with memReady low.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT with memReady still low, next state is TRAP.
  - memReady high on the same cycle as the limit wins: normal transition, no trap.
- memReady is ignored outside memory states.

## Timing
- Reset: state=START, all outputs 0, trap 0, counter 0, latched opcode 000000.
- Outputs are pure decodes of state, latched opcode and memReady. No output registers.
- Latency with memReady tied high:
  - R-type, addi, andi, sw: 4 cycles
  - lw: 5 cycles
  - beq, bne, j: 3 cycles
- Each memory stall adds one cycle.
- Reset asserted mid-instruction returns to START immediately. No partial write is issued after reset assertion.

## Configuration
- CTRL_JAL_EN defined:
  - Opcode 000011 (jal) goes DECODE → JAL.
  - JAL asserts pcWrite, PCSource=10, regWrite, and a new output link (1 bit, reset 0) that selects $31 as destination and PC as write data. Next FETCH.
- CTRL_JAL_EN undefined: link port absent; 000011 traps.

## Structure
- multicycle_pkg holds:
  - state encoding (4-bit localparams)
  - opcode constants
  - ALUOp, ALUSrcB and PCSource codes
- Sub-module mem_wait_timer: CNT_W-bit counter with clear/enable inputs and an expired output, parametrised by MEM_TIMEOUT.

## Test plan
- R-type opCode=000000, memReady=1: states START→FETCH→DECODE→R_EXEC→R_WB→FETCH; regDst=1, regWrite=1 only in R_WB.
- lw with memReady low for 3 cycles in MEM_READ: memRead=1 and iorD=1 held 4 cycles; MEM_WB follows with memReg=1, regWrite=1.
- beq, then bne: pcWriteCond=1 (first) or pcWriteCondNe=1 (second) with ALUOp=01 and PCSource=01, for exactly one cycle each.
- opCode=111111: DECODE→TRAP, trap=1 and all other outputs 0 held for 20 cycles until rst_n low.
- MEM_TIMEOUT=4, memReady stuck low in FETCH: TRAP on the 5th cycle. Repeat with memReady rising on the 4th wait cycle: DECODE, no trap.
- rst_n dropped mid-MEM_WRITE: memWrite falls asynchronously, state=START. After release, FETCH next cycle.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes, opcodes
// and datapath mux/ALU select codes.
`timescale 1ns/1ps
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12,
    S_TRAP      = 4'd13,
    S_JAL       = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles in a memory state; o_expired flags that a stall in the
// current cycle would bring the count to MEM_TIMEOUT (0 disables expiry).
`timescale 1ns/1ps
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LIMIT = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (MEM_TIMEOUT != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath with memory-ready wait,
// bounded by MEM_TIMEOUT, and a sticky trap. Define CTRL_JAL_EN to add jal.
`timescale 1ns/1ps
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       pcWriteCondNe,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       trap,
`ifdef CTRL_JAL_EN
  output logic       link,
`endif
  output logic [3:0] state
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op;
  logic       w_expired;
  logic       w_stall;
  logic       w_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_START;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= opCode;
    end
  end

  // Any state change restarts the wait count, so every memory state starts at 0.
  assign w_stall = is_mem_state(r_state) && !memReady;
  assign w_clr   = (w_next != r_state);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_en      (w_stall),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_START:  w_next = S_FETCH;
      S_FETCH:  if (memReady) w_next = S_DECODE; else if (w_expired) w_next = S_TRAP;
      S_DECODE: begin
        case (opCode)
          OP_LW, OP_SW:     w_next = S_MEM_ADDR;
          OP_RTYPE:         w_next = S_R_EXEC;
          OP_BEQ, OP_BNE:   w_next = S_BRANCH;
          OP_J:             w_next = S_JUMP;
          OP_ADDI, OP_ANDI: w_next = S_I_EXEC;
`ifdef CTRL_JAL_EN
          OP_JAL:           w_next = S_JAL;
`endif
          default:          w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  w_next = (r_op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (memReady) w_next = S_MEM_WB; else if (w_expired) w_next = S_TRAP;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: if (memReady) w_next = S_FETCH; else if (w_expired) w_next = S_TRAP;
      S_R_EXEC:    w_next = S_R_WB;
      S_R_WB:      w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      S_I_EXEC:    w_next = S_I_WB;
      S_I_WB:      w_next = S_FETCH;
      S_TRAP:      w_next = S_TRAP;
`ifdef CTRL_JAL_EN
      S_JAL:       w_next = S_FETCH;
`endif
      default:     w_next = S_TRAP;
    endcase
  end

  always_comb begin
    pcWrite       = 1'b0;
    pcWriteCond   = 1'b0;
    pcWriteCondNe = 1'b0;
    iorD          = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    irWrite       = 1'b0;
    memReg        = 1'b0;
    regDst        = 1'b0;
    regWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_RT;
    ALUOp         = ALUOP_ADD;
    PCSource      = PCSRC_ALU;
    trap          = 1'b0;
`ifdef CTRL_JAL_EN
    link          = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        memRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        pcWrite = memReady;
        irWrite = memReady;
      end
      S_DECODE:    ALUSrcB = SRCB_SHIMM;
      S_MEM_ADDR:  begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
      S_MEM_READ:  begin memRead = 1'b1; iorD = 1'b1; end
      S_MEM_WB:    begin memReg = 1'b1; regWrite = 1'b1; end
      S_MEM_WRITE: begin memWrite = 1'b1; iorD = 1'b1; end
      S_R_EXEC:    begin ALUSrcA = 1'b1; ALUOp = ALUOP_FUNCT; end
      S_R_WB:      begin regDst = 1'b1; regWrite = 1'b1; end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = ALUOP_SUB;
        PCSource      = PCSRC_ALUOUT;
        pcWriteCond   = (r_op == OP_BEQ);
        pcWriteCondNe = (r_op == OP_BNE);
      end
      S_JUMP:      begin pcWrite = 1'b1; PCSource = PCSRC_JUMP; end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = (r_op == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
      end
      S_I_WB:      regWrite = 1'b1;
      S_TRAP:      trap = 1'b1;
`ifdef CTRL_JAL_EN
      S_JAL: begin
        pcWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        regWrite = 1'b1;
        link     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: random instruction stream with
// random memory stalls, illegal opcodes, timeouts and async resets.
`timescale 1ns/1ps
module tb_multicycle_control;
  import multicycle_pkg::*;

  localparam int MEM_TO = 4;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_ANDI = 6'b001100;
  localparam logic [5:0] T_JAL  = 6'b000011;

  typedef struct packed {
    logic [3:0] st;
    logic       trap;
    logic       link;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       pcWriteCondNe;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memReg;
    logic       regDst;
    logic       regWrite;
    logic       ALUSrcA;
    logic [1:0] srcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opCode = '0;
  logic       memReady = 1'b0;
  logic       pcWrite, pcWriteCond, pcWriteCondNe, iorD, memRead, memWrite, irWrite;
  logic       memReg, regDst, regWrite, ALUSrcA, trap;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  wire        link_w;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;
  logic [5:0] legal[$];

  multicycle_control #(.MEM_TIMEOUT(MEM_TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcWriteCondNe(pcWriteCondNe),
    .iorD(iorD), .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .memReg(memReg), .regDst(regDst), .regWrite(regWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .trap(trap),
`ifdef CTRL_JAL_EN
    .link(link_w),
`endif
    .state(state)
  );
`ifndef CTRL_JAL_EN
  assign link_w = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic exp_t blank(input logic [3:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: inputs for this cycle and the output expected during it.
  task automatic cyc(input logic rdy, input logic [5:0] op, input exp_t e);
    @(posedge clk);
    #1;
    memReady = rdy;
    opCode   = op;
    sb.push_back(e);
  endtask

  // Drops rst_n mid-cycle (outputs must go to START before the next edge),
  // holds it two more cycles, releases it with START still expected.
  task automatic reset_seq();
    @(posedge clk);
    #1;
    memReady = 1'($urandom_range(0, 1));
    sb.push_back(blank(S_START));
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (state !== S_START) begin
      n_fail++;
      $display("FAIL async reset: state=%0d expected START", state);
    end
    n_tests++;
    if (memWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL async reset: memWrite still high");
    end
    n_tests++;
    if ((memRead | pcWrite | regWrite | trap) !== 1'b0) begin
      n_fail++;
      $display("FAIL async reset: outputs not cleared");
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      sb.push_back(blank(S_START));
    end
    rst_n = 1'b1;
  endtask

  task automatic trap_then_reset();
    exp_t e;
    e = blank(S_TRAP);
    e.trap = 1'b1;
    for (int k = 0; k < 20; k++) cyc(1'($urandom_range(0, 1)), 6'($urandom), e);
    reset_seq();
  endtask

  // Memory state with `stall` low cycles before memReady; stall >= MEM_TO traps.
  task automatic mem_phase(input exp_t base, input int stall, input logic [5:0] op,
                           input bit is_fetch, output bit trapped);
    exp_t e;
    logic rdy;
    trapped = 1'b1;
    for (int k = 0; k < MEM_TO; k++) begin
      e   = base;
      rdy = (k == stall);
      if (is_fetch && rdy) begin
        e.pcWrite = 1'b1;
        e.irWrite = 1'b1;
      end
      cyc(rdy, op, e);
      if (rdy) begin
        trapped = 1'b0;
        break;
      end
    end
  endtask

  task automatic issue(input logic [5:0] op, input int fs, input int ms);
    exp_t e;
    bit   tr;
    e = blank(S_FETCH);
    e.memRead = 1'b1;
    e.srcB    = 2'b01;
    mem_phase(e, fs, op, 1'b1, tr);
    if (tr) begin
      trap_then_reset();
      return;
    end
    e = blank(S_DECODE);
    e.srcB = 2'b11;
    cyc(1'($urandom_range(0, 1)), op, e);
    case (op)
      T_LW, T_SW: begin
        e = blank(S_MEM_ADDR);
        e.ALUSrcA = 1'b1;
        e.srcB    = 2'b10;
        cyc(1'($urandom_range(0, 1)), 6'($urandom), e);
        e = blank((op == T_LW) ? S_MEM_READ : S_MEM_WRITE);
        e.iorD     = 1'b1;
        e.memRead  = (op == T_LW);
        e.memWrite = (op == T_SW);
        mem_phase(e, ms, 6'($urandom), 1'b0, tr);
        if (tr) begin
          trap_then_reset();
          return;
        end
        if (op == T_LW) begin
          e = blank(S_MEM_WB);
          e.memReg   = 1'b1;
          e.regWrite = 1'b1;
          cyc(1'($urandom_range(0, 1)), 6'($urandom), e);
        end
      end
      T_R: begin
        e = blank(S_R_EXEC);
        e.ALUSrcA = 1'b1;
        e.aluOp   = 2'b10;
        cyc(1'($urandom_range(0, 1)), 6'($urandom), e);
        e = blank(S_R_WB);
        e.regDst   = 1'b1;
        e.regWrite = 1'b1;
        cyc(1'($urandom_range(0, 1)), 6'($urandom), e);
      end
      T_BEQ, T_BNE: begin
        e = blank(S_BRANCH);
        e.ALUSrcA       = 1'b1;
        e.aluOp         = 2'b01;
        e.pcSrc         = 2'b01;
        e.pcWriteCond   = (op == T_BEQ);
        e.pcWriteCondNe = (op == T_BNE);
        cyc(1'($urandom_range(0, 1)), 6'($urandom), e);
      end
      T_J: begin
        e = blank(S_JUMP);
        e.pcWrite = 1'b1;
        e.pcSrc   = 2'b10;
        cyc(1'($urandom_range(0, 1)), 6'($urandom), e);
      end
      T_ADDI, T_ANDI: begin
        e = blank(S_I_EXEC);
        e.ALUSrcA = 1'b1;
        e.srcB    = 2'b10;
        e.aluOp   = (op == T_ANDI) ? 2'b11 : 2'b00;
        cyc(1'($urandom_range(0, 1)), 6'($urandom), e);
        e = blank(S_I_WB);
        e.regWrite = 1'b1;
        cyc(1'($urandom_range(0, 1)), 6'($urandom), e);
      end
`ifdef CTRL_JAL_EN
      T_JAL: begin
        e = blank(S_JAL);
        e.pcWrite  = 1'b1;
        e.pcSrc    = 2'b10;
        e.regWrite = 1'b1;
        e.link     = 1'b1;
        cyc(1'($urandom_range(0, 1)), 6'($urandom), e);
      end
`endif
      default: trap_then_reset();
    endcase
  endtask

  // Monitor: outputs are valid every cycle, so each negedge retires one entry.
  always @(negedge clk) begin
    exp_t a, x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      a = '{st: state, trap: trap, link: link_w, pcWrite: pcWrite,
            pcWriteCond: pcWriteCond, pcWriteCondNe: pcWriteCondNe, iorD: iorD,
            memRead: memRead, memWrite: memWrite, irWrite: irWrite, memReg: memReg,
            regDst: regDst, regWrite: regWrite, ALUSrcA: ALUSrcA, srcB: ALUSrcB,
            aluOp: ALUOp, pcSrc: PCSource};
      n_tests++;
      if (a !== x) begin
        n_fail++;
        $display("FAIL cycle t=%0t state got=%0d exp=%0d outputs got=%h exp=%h",
                 $time, a.st, x.st, a, x);
      end
    end else if (done) begin
      if (n_tests == 0) begin
        n_fail++;
        $display("FAIL no checks were retired");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [5:0] op;
    int fs, ms;
    legal = '{T_R, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_ADDI, T_ANDI};
`ifdef CTRL_JAL_EN
    legal.push_back(T_JAL);
`endif
    reset_seq();

    issue(T_R, 0, 0);
    issue(T_LW, 0, 3);
    issue(T_BEQ, 0, 0);
    issue(T_BNE, 0, 0);
    issue(6'b111111, 0, 0);
    issue(T_R, MEM_TO, 0);
    issue(T_R, MEM_TO - 1, 0);
    issue(T_SW, 1, MEM_TO);
    issue(T_JAL, 0, 0);

    // sw interrupted by reset while MEM_WRITE is still waiting
    e = blank(S_FETCH);
    e.memRead = 1'b1; e.srcB = 2'b01; e.pcWrite = 1'b1; e.irWrite = 1'b1;
    cyc(1'b1, T_SW, e);
    e = blank(S_DECODE);
    e.srcB = 2'b11;
    cyc(1'b0, T_SW, e);
    e = blank(S_MEM_ADDR);
    e.ALUSrcA = 1'b1; e.srcB = 2'b10;
    cyc(1'b1, T_SW, e);
    e = blank(S_MEM_WRITE);
    e.memWrite = 1'b1; e.iorD = 1'b1;
    cyc(1'b0, T_SW, e);
    cyc(1'b0, T_SW, e);
    reset_seq();
    issue(T_ADDI, 0, 0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 99) < 6) begin
        op = 6'($urandom);
        if (is_legal(op)) op = 6'b111111;
      end else begin
        op = legal[$urandom_range(0, legal.size() - 1)];
      end
      fs = ($urandom_range(0, 29) == 0) ? MEM_TO : $urandom_range(0, MEM_TO - 1);
      ms = ($urandom_range(0, 19) == 0) ? MEM_TO : $urandom_range(0, MEM_TO - 1);
      issue(op, fs, ms);
    end

    @(negedge clk);
    #1 done = 1'b1;
  end

endmodule
